// File: rtl/uart_cmd_decoder.sv
// Pops bytes from the RX FIFO and decodes single-letter commands and the
// "S hhmmss <CR|LF>" set-time command into registered one-cycle pulses.
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  output logic       rx_pop,
  output logic       o_run_stop,
  output logic       o_clear,
  output logic       o_mode,
  output logic       o_dht_req,
  output logic       o_set_valid,
  output logic [4:0] o_set_hour,
  output logic [5:0] o_set_min,
  output logic [5:0] o_set_sec,
  output logic       o_err,
  output logic [1:0] dbg_state
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIGITS = 2'd1,
    TERM   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [5:0][3:0] digit_q, digit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            run_stop_q, run_stop_d, clear_q, clear_d, mode_q, mode_d;
  logic            dht_req_q, dht_req_d, set_valid_q, set_valid_d, err_q, err_d;
  logic [4:0]      set_hour_q, set_hour_d;
  logic [5:0]      set_min_q, set_min_d, set_sec_q, set_sec_d;

  logic       is_digit, is_eol, timeout;
  logic [6:0] hour_v, min_v, sec_v;

  function automatic logic [6:0] times10(input logic [3:0] x);
    logic [6:0] w;
    w = {3'b000, x};
    return (w << 3) + (w << 1);
  endfunction

  assign rx_pop    = ~rx_empty;
  assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_eol    = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  // A pop in the limit cycle wins over the timeout.
  assign timeout   = ~rx_pop && (cnt_q == CNT_MAX);
  assign hour_v    = times10(digit_q[0]) + {3'b000, digit_q[1]};
  assign min_v     = times10(digit_q[2]) + {3'b000, digit_q[3]};
  assign sec_v     = times10(digit_q[4]) + {3'b000, digit_q[5]};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    digit_d     = digit_q;
    cnt_d       = cnt_q;
    run_stop_d  = 1'b0;
    clear_d     = 1'b0;
    mode_d      = 1'b0;
    dht_req_d   = 1'b0;
    set_valid_d = 1'b0;
    err_d       = 1'b0;
    set_hour_d  = set_hour_q;
    set_min_d   = set_min_q;
    set_sec_d   = set_sec_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_pop) begin
          case (rx_data)
            8'h52, 8'h72: run_stop_d = 1'b1;
            8'h43, 8'h63: clear_d    = 1'b1;
            8'h4D, 8'h6D: mode_d     = 1'b1;
            8'h44, 8'h64: dht_req_d  = 1'b1;
            8'h53, 8'h73: begin
              state_d = DIGITS;
              idx_d   = 3'd0;
            end
            8'h0D, 8'h0A: ;
            default:      err_d = 1'b1;
          endcase
        end
      end
      DIGITS: begin
        if (rx_pop) begin
          cnt_d = '0;
          if (is_digit) begin
            digit_d[idx_q] = rx_data[3:0];
            if (idx_q == 3'd5) state_d = TERM;
            else               idx_d   = idx_q + 3'd1;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TERM: begin
        if (rx_pop) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (is_eol && (hour_v < 7'd24) && (min_v < 7'd60) && (sec_v < 7'd60)) begin
            set_valid_d = 1'b1;
            set_hour_d  = hour_v[4:0];
            set_min_d   = min_v[5:0];
            set_sec_d   = sec_v[5:0];
          end else begin
            err_d = 1'b1;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      digit_q     <= '0;
      cnt_q       <= '0;
      run_stop_q  <= 1'b0;
      clear_q     <= 1'b0;
      mode_q      <= 1'b0;
      dht_req_q   <= 1'b0;
      set_valid_q <= 1'b0;
      err_q       <= 1'b0;
      set_hour_q  <= '0;
      set_min_q   <= '0;
      set_sec_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      digit_q     <= digit_d;
      cnt_q       <= cnt_d;
      run_stop_q  <= run_stop_d;
      clear_q     <= clear_d;
      mode_q      <= mode_d;
      dht_req_q   <= dht_req_d;
      set_valid_q <= set_valid_d;
      err_q       <= err_d;
      set_hour_q  <= set_hour_d;
      set_min_q   <= set_min_d;
      set_sec_q   <= set_sec_d;
    end
  end

  assign o_run_stop  = run_stop_q;
  assign o_clear     = clear_q;
  assign o_mode      = mode_q;
  assign o_dht_req   = dht_req_q;
  assign o_set_valid = set_valid_q;
  assign o_err       = err_q;
  assign o_set_hour  = set_hour_q;
  assign o_set_min   = set_min_q;
  assign o_set_sec   = set_sec_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: directed command scenarios then random byte
// streams, checked every cycle against a queue-based command interpreter.
module tb_uart_cmd_decoder;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_empty;
  logic [7:0] rx_data;
  logic       rx_pop;
  logic       o_run_stop, o_clear, o_mode, o_dht_req, o_set_valid, o_err;
  logic [4:0] o_set_hour;
  logic [5:0] o_set_min, o_set_sec;
  logic [1:0] dbg_state;

  uart_cmd_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_data(rx_data), .rx_pop(rx_pop),
    .o_run_stop(o_run_stop), .o_clear(o_clear), .o_mode(o_mode), .o_dht_req(o_dht_req),
    .o_set_valid(o_set_valid), .o_set_hour(o_set_hour), .o_set_min(o_set_min),
    .o_set_sec(o_set_sec), .o_err(o_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected {run,clear,mode,dht,set_valid,err, hour, min, sec}
  logic [22:0] exp_q[$];

  // Reference interpreter: pending set-time characters kept in a queue.
  bit         m_in_set;
  int         m_digits[$];
  int         m_idle;
  logic [4:0] m_h;
  logic [5:0] m_m, m_s;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(bit r, bit pop, logic [7:0] b);
    logic [5:0] p;
    int h, mi, s;
    p = 6'b0;
    if (r) begin
      m_in_set = 0; m_digits.delete(); m_idle = 0;
      m_h = 0; m_m = 0; m_s = 0;
    end else if (pop) begin
      m_idle = 0;
      if (!m_in_set) begin
        if (b == 8'h52 || b == 8'h72)      p[5] = 1;
        else if (b == 8'h43 || b == 8'h63) p[4] = 1;
        else if (b == 8'h4D || b == 8'h6D) p[3] = 1;
        else if (b == 8'h44 || b == 8'h64) p[2] = 1;
        else if (b == 8'h53 || b == 8'h73) begin m_in_set = 1; m_digits.delete(); end
        else if (b != 8'h0D && b != 8'h0A) p[0] = 1;
      end else if (m_digits.size() < 6) begin
        if (b >= 8'h30 && b <= 8'h39) m_digits.push_back(int'(b) - 48);
        else begin p[0] = 1; m_in_set = 0; end
      end else begin
        h  = m_digits[0] * 10 + m_digits[1];
        mi = m_digits[2] * 10 + m_digits[3];
        s  = m_digits[4] * 10 + m_digits[5];
        if ((b == 8'h0D || b == 8'h0A) && h < 24 && mi < 60 && s < 60) begin
          p[1] = 1; m_h = 5'(h); m_m = 6'(mi); m_s = 6'(s);
        end else p[0] = 1;
        m_in_set = 0;
      end
    end else if (m_in_set) begin
      if (m_idle == T - 1) begin p[0] = 1; m_in_set = 0; m_idle = 0; end
      else m_idle++;
    end
    exp_q.push_back({p, m_h, m_m, m_s});
  endtask

  // One clock cycle: drive, check rx_pop, clock, model, check registered outputs.
  task automatic step(bit empty, logic [7:0] data, bit r);
    logic [22:0] e;
    rx_empty = empty; rx_data = data; rst = r;
    #1 chk("rx_pop", 32'(rx_pop), 32'(!empty));
    @(posedge clk);
    model(r, !empty, data);
    #1;
    if (exp_q.size() == 0) begin
      chk("exp_q_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("pulses", 32'({o_run_stop, o_clear, o_mode, o_dht_req, o_set_valid, o_err}), 32'(e[22:17]));
      chk("set_time", 32'({o_set_hour, o_set_min, o_set_sec}), 32'(e[16:0]));
    end
  endtask

  task automatic send(string s);
    for (int i = 0; i < s.len(); i++) step(1'b0, s[i], 1'b0);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b1, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    int sel;
    string cmds;
    cmds = "RrCcMmDd\r\n";
    m_in_set = 0; m_idle = 0; m_h = 0; m_m = 0; m_s = 0;
    rst = 1'b1; rx_empty = 1'b1; rx_data = 8'h00;
    #2;
    step(1'b1, 8'h00, 1'b1);
    step(1'b0, 8'h72, 1'b1);  // popped during reset, discarded
    idle(2);

    send("r"); idle(2);
    send("rcmd"); idle(2);
    send("S123456\r"); idle(3);
    chk("hour_12", 32'(o_set_hour), 32'd12);
    chk("min_34", 32'(o_set_min), 32'd34);
    chk("sec_56", 32'(o_set_sec), 32'd56);
    send("S245959\r"); idle(2);
    chk("hour_held", 32'(o_set_hour), 32'd12);
    send("S12a"); send("c"); idle(2);
    send("s235959\n"); idle(1);
    chk("hour_23", 32'(o_set_hour), 32'd23);
    send("S12"); idle(T - 1);
    chk("no_early_timeout", 32'(o_err), 32'd0);
    idle(1);
    chk("timeout_err", 32'(o_err), 32'd1);
    send("r"); idle(1);
    send("S12345"); idle(T - 1); send("6\r"); idle(2);  // pop at the limit cycle
    send("S1234");
    step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'h00, 1'b0);
    send("56\r"); idle(2);
    send("xS1\r"); idle(2);

    for (int it = 0; it < 300; it++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 3) begin
        b = cmds[$urandom_range(0, cmds.len() - 1)];
        step(1'b0, b, 1'b0);
      end else if (sel <= 6) begin
        step(1'b0, ($urandom_range(0, 1) != 0) ? 8'h53 : 8'h73, 1'b0);
        for (int d = 0; d < 6; d++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, T));
          b = 8'(48 + (((d % 2) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 9)));
          if ($urandom_range(0, 29) == 0) b = 8'($urandom_range(0, 255));
          step(1'b0, b, 1'b0);
        end
        sel = $urandom_range(0, 9);
        b = (sel < 5) ? 8'h0D : (sel < 9) ? 8'h0A : 8'($urandom_range(0, 255));
        step(1'b0, b, 1'b0);
      end else if (sel == 7) begin
        step(1'b0, 8'($urandom_range(0, 255)), 1'b0);
      end else if (sel == 8) begin
        idle($urandom_range(0, T + 4));
      end else begin
        step(1'b1, 8'h00, 1'b1);
      end
      if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 2));
    end
    idle(T + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
